// File: rtl/btn_debounce_if.sv
// Button-side signal bundle for btn_debounce: raw pins in, debounced level and
// edge pulses out. The debouncer takes the slave view; whoever drives the pins takes the master view.
interface btn_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_in;
  logic [WIDTH-1:0] btn_state;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (
    output btn_in,
    input  btn_state,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_state,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel button debouncer. It uses a two-flop synchronizer and a stability-window FSM.
// It produces a registered clean level and single-cycle press/release pulses.
module btn_debounce #(
  parameter int WIDTH     = 4,
  parameter int LOG2DELAY = 16
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave btns
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [LOG2DELAY-1:0] CNT_LAST = '1;

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values; with blocking, sync1 would copy the new sync0 in
  // the same edge and collapse the chain to one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btns.btn_in;
      sync1 <= sync0;
    end
  end

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
    state_t               state;
    state_t               state_nxt;
    logic [LOG2DELAY-1:0] cnt;
    logic [LOG2DELAY-1:0] cnt_nxt;
    logic                 level;
    logic                 level_nxt;
    logic                 press;
    logic                 press_nxt;
    logic                 release_q;
    logic                 release_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= STABLE_LO;
        cnt       <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level     <= level_nxt;
        press     <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // NOTE: every output of this block is given a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      unique case (state)
        STABLE_LO: begin
          if (sync1[ch]) begin
            state_nxt = WAIT_HI;
            cnt_nxt   = '0;
          end
        end
        WAIT_HI: begin
          // A drop back to 0 discards the partial count; glitches never add up.
          if (!sync1[ch]) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!sync1[ch]) begin
            state_nxt = WAIT_LO;
            cnt_nxt   = '0;
          end
        end
        WAIT_LO: begin
          if (sync1[ch]) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = STABLE_LO;
            cnt_nxt     = '0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign btns.btn_state[ch]   = level;
    assign btns.btn_press[ch]   = press;
    assign btns.btn_release[ch] = release_q;
  end

endmodule
